// File: rtl/ha_pkg.sv
// Shared types and defaults for the HA dataflow token channel.
package ha_pkg;
  localparam int unsigned HA_TOKEN_BW   = 32;
  localparam int unsigned HA_FIFO_DEPTH = 4;
  localparam int unsigned HA_CNT_BW     = 32;

  typedef logic [HA_TOKEN_BW-1:0] ha_token_t;

  // Per-cycle occupancy change, encoded as {push, pop}.
  typedef enum logic [1:0] {
    HA_OP_IDLE = 2'b00,
    HA_OP_POP  = 2'b01,
    HA_OP_PUSH = 2'b10,
    HA_OP_BOTH = 2'b11
  } ha_fifo_op_e;
endpackage

// File: rtl/ha_token_fifo_if.sv
// Upstream and downstream valid/ready token handshakes of the token FIFO.
interface ha_token_fifo_if
  import ha_pkg::*;
#(
  parameter int unsigned DataIn_1_BW = HA_TOKEN_BW
);
  logic [DataIn_1_BW-1:0] DataIn_1;
  logic                   DataIn_1_valid;
  logic                   DataIn_1_ready;
  logic [DataIn_1_BW-1:0] DataOut_1;
  logic                   DataOut_1_valid;
  logic                   DataOut_1_ready;

  modport master (
    output DataIn_1, DataIn_1_valid, DataOut_1_ready,
    input  DataIn_1_ready, DataOut_1, DataOut_1_valid
  );

  modport slave (
    input  DataIn_1, DataIn_1_valid, DataOut_1_ready,
    output DataIn_1_ready, DataOut_1, DataOut_1_valid
  );
endinterface

// File: rtl/ha_fifo_mem.sv
// DEPTH x width register array: one synchronous write port, one asynchronous read port.
module ha_fifo_mem
  import ha_pkg::*;
#(
  parameter  int unsigned DataIn_1_BW = HA_TOKEN_BW,
  parameter  int unsigned DEPTH       = HA_FIFO_DEPTH,
  localparam int unsigned PTR_W       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [PTR_W-1:0]       i_wr_addr,
  input  logic [DataIn_1_BW-1:0] i_wr_data,
  input  logic [PTR_W-1:0]       i_rd_addr,
  output logic [DataIn_1_BW-1:0] o_rd_data
);
  logic [DataIn_1_BW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/ha_token_fifo.sv
// Elastic first-word-fall-through token FIFO with occupancy and consumed-token counter.
module ha_token_fifo
  import ha_pkg::*;
#(
  parameter int unsigned DataIn_1_BW = HA_TOKEN_BW,
  parameter int unsigned DEPTH       = HA_FIFO_DEPTH,
  parameter int unsigned CNT_BW      = HA_CNT_BW
) (
  input  logic                   clk,
  input  logic                   rst,
  ha_token_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Full,
  output logic                   Empty,
  output logic [CNT_BW-1:0]      TokTotal
);
  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  logic                   r_full;
  logic                   r_empty;
  logic [CNT_BW-1:0]      r_tok_total;
  logic                   w_in_ready;
  logic                   w_push;
  logic                   w_pop;
  ha_fifo_op_e            w_op;
  logic [DataIn_1_BW-1:0] w_rd_data;

  // Ready comes from the registered full flag only, so a same-cycle pop never raises it.
  assign w_in_ready = !r_full && !rst;
  assign w_push     = bus.DataIn_1_valid && w_in_ready;
  assign w_pop      = !r_empty && bus.DataOut_1_ready && !rst;
  assign w_op       = ha_fifo_op_e'({w_push, w_pop});

  always_comb begin
    w_count_nxt = r_count;
    unique case (w_op)
      HA_OP_PUSH: w_count_nxt = r_count + CNT_W'(1);
      HA_OP_POP:  w_count_nxt = r_count - CNT_W'(1);
      default:    w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_tok_total <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_tok_total <= r_tok_total + CNT_BW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  ha_fifo_mem #(
    .DataIn_1_BW (DataIn_1_BW),
    .DEPTH       (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.DataIn_1),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign bus.DataIn_1_ready  = w_in_ready;
  assign bus.DataOut_1_valid = !r_empty;
  assign bus.DataOut_1       = r_empty ? '0 : w_rd_data;
  assign Count               = r_count;
  assign Full                = r_full;
  assign Empty               = r_empty;
  assign TokTotal            = r_tok_total;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) r_full |-> !w_push);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) r_empty |-> !w_pop);
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.DataOut_1_valid && !bus.DataOut_1_ready) |=> $stable(bus.DataOut_1));
endmodule

// File: doc/ha_token_fifo.md
Name: ha_token_fifo

Overview:
- Elastic token channel between HA dataflow stages. It sits directly downstream of a token wrapper stage (Token → ha_token_fifo → output wrapper).
- Buffers 32-bit tokens with valid/ready handshakes on both sides, so the producer and consumer stages can stall independently.
- Reports occupancy and a running count of consumed tokens for DSE instrumentation.

Parameters:
- DataIn_1_BW, 32, token width on both sides.
- DEPTH, 4, number of entries. Must be a power of two, ≥ 2.
- CNT_BW, 32, width of the consumed-token counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- DataIn_1  input  DataIn_1_BW  upstream token.
- DataIn_1_valid  input  1  upstream token is valid.
- DataIn_1_ready  output  1  FIFO accepts a token this cycle.
- DataOut_1  output  DataIn_1_BW  head token.
- DataOut_1_valid  output  1  head token is valid.
- DataOut_1_ready  input  1  downstream consumes the head token.
- Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- TokTotal  output  CNT_BW  tokens popped since reset.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset (rst high at a clk edge):
  - Pointers and Count clear to 0; TokTotal clears to 0.
  - Empty=1, Full=0, DataOut_1_valid=0, DataOut_1=0.
  - DataIn_1_ready is forced to 0 while rst is high and is 1 in the first cycle after rst deasserts.
  - Storage array is not reset.
  - Reset mid-operation discards all stored tokens. No handshake completes in a cycle where rst is high.
- Push: occurs when DataIn_1_valid && DataIn_1_ready at the edge. DataIn_1 is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- Pop: occurs when DataOut_1_valid && DataOut_1_ready at the edge. rd_ptr increments modulo DEPTH and TokTotal increments, wrapping from 2^CNT_BW-1 to 0.
- DataIn_1_ready = !Full && !rst. Registered full flag; no combinational path from DataOut_1_ready.
- DataOut_1_valid = !Empty.
- DataOut_1 = mem[rd_ptr] when !Empty, else 0 (first-word fall-through).
- Latency: a token pushed at edge N is visible on DataOut_1 with valid=1 in the cycle after edge N. Minimum in-to-out latency is 1 cycle; there is no same-cycle bypass.
- Count update at each edge:
  - +1 on push only; −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full: push is blocked (ready=0). A pop in the same cycle frees a slot, but ready rises only in the next cycle.
- Empty: DataOut_1_valid=0. A downstream ready on an empty FIFO has no effect (no underflow, TokTotal unchanged).
- Simultaneous push and pop with Count=1: the old head is popped and the new token becomes the head next cycle. Count stays 1.
- Pointer width is $clog2(DEPTH). Full/Empty derive from a separate Count register, not from pointer comparison.
- Assertions (verification):
  - Count ≤ DEPTH.
  - No push while Full.
  - No pop while Empty.
  - DataOut_1 stable while valid && !ready.

Decomposition:
- Shared package ha_pkg:
  - HA_TOKEN_BW = 32.
  - typedef ha_token_t (logic [HA_TOKEN_BW-1:0]).
  - clog2 helper / default depth constant HA_FIFO_DEPTH = 4.
- One natural sub-module: ha_fifo_mem, a DEPTH×DataIn_1_BW register array with one write port and an asynchronous read port.
- Control (pointers, count, flags, counter) stays in ha_token_fifo.

Test Plan:
- Reset then idle: rst high 2 cycles with DataIn_1_valid=1 → no push, Count=0, ready=0 during reset. Ready=1 the cycle after rst drops.
- Fill and drain, DEPTH=4: push 0xA0..0xA3 with DataOut_1_ready=0 → Full=1, ready=0, Count=4. A 5th token 0xA4 held valid is not accepted. Then ready=1 for 4 cycles → outputs A0,A1,A2,A3 in order, TokTotal=4, Empty=1.
- Streaming: valid=1 and ready=1 continuously with 0x1..0x10 → Count holds 1 after the first cycle, all 16 tokens emerge in order with 1-cycle latency, TokTotal=16.
- Full with simultaneous pop: at Count=4, pop one → Count=3 next cycle and ready=1 only next cycle. Push 0xB0 → it exits after the 3 older tokens.
- Backpressure stability: random DataOut_1_ready toggling, 100 tokens → DataOut_1 stable while stalled, no loss or duplication, TokTotal=100. Pointer wrap exercised at least 25 times.
- Reset mid-operation: Count=3 (0xC0..0xC2), assert rst 1 cycle → Empty=1, TokTotal=0, DataOut_1=0. Next push 0xD0 emerges first.
